fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0040_0000, giving the architectural PC loaded on reset.
REQ-002 The block SHALL have parameter MEM_OFFSET, default 32'hFFC0_0000, added to the PC to form the physical instruction-memory address.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port stall, input, 1 bit: hazard request to hold the PC and the IF/ID register.
REQ-006 The block SHALL have port flush, input, 1 bit: request to replace the IF/ID contents with a bubble.
REQ-007 The block SHALL have port redirect_valid, input, 1 bit: the branch/jump/jr target from a later stage is valid this cycle.
REQ-008 The block SHALL have port redirect_pc, input, 32 bits: the redirect target PC.
REQ-009 The block SHALL have port imem_instr, input, 32 bits: the combinational instruction-memory read data for imem_addr.
REQ-010 The block SHALL have port imem_addr, output, 32 bits: the physical fetch address.
REQ-011 The block SHALL have port pc, output, 32 bits: the current architectural PC.
REQ-012 The block SHALL have port id_instr, output, 32 bits: the registered instruction presented to decode.
REQ-013 The block SHALL have port id_pc_4, output, 32 bits: the registered PC+4 of id_instr.
REQ-014 The block SHALL have port id_valid, output, 1 bit: id_instr is a real instruction, not a bubble.
REQ-015 The block SHALL have port fetch_count, output, 32 bits: the number of instructions delivered to decode.
REQ-016 The block SHALL have port squash_count, output, 32 bits: the number of instructions discarded.

Function
REQ-017 imem_addr SHALL equal pc + MEM_OFFSET combinationally, computed modulo 2^32.
REQ-018 pc_plus4 SHALL equal pc + 4 modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-019 The next PC SHALL be selected with priority redirect_valid (load {redirect_pc[31:2],2'b00}) > stall (hold) > pc_plus4.
REQ-020 IF/ID update priority SHALL be (flush or redirect_valid) -> bubble > stall -> hold > load {imem_instr, pc_plus4, valid=1}.
REQ-021 A bubble SHALL set id_instr=32'h0000_0000 (NOP), id_pc_4=32'h0, and id_valid=0.
REQ-022 Latency SHALL be one cycle: the instruction at pc in cycle N appears on id_instr in cycle N+1 when that cycle is neither stalled nor squashed.
REQ-023 When stall=1 and flush=1 together, the PC SHALL hold and IF/ID SHALL take a bubble.
REQ-024 When redirect_valid=1 and stall=1 together, the PC SHALL take the redirect and IF/ID SHALL take a bubble.
REQ-025 The instruction fetched in a redirect cycle SHALL never reach decode.
REQ-026 While stall=1 is held for K cycles, pc and all IF/ID outputs SHALL remain constant for those K cycles.
REQ-027 The block SHALL contain no combinational path from stall, flush or redirect_* to any registered output.

Reset
REQ-028 When reset=1 is sampled at a clock edge: pc=RESET_PC, id_instr=0, id_pc_4=0, id_valid=0, fetch_count=0, squash_count=0.
REQ-029 Reset SHALL override stall, flush and redirect_valid, including in the middle of a stall sequence.
REQ-030 In the first cycle after reset deasserts, the block SHALL fetch RESET_PC, and id_valid SHALL rise one cycle later.

Configuration
REQ-031 Macro FETCH_PERF_EN, when defined, SHALL compile in both counters.
REQ-032 With FETCH_PERF_EN defined, fetch_count SHALL increment on each IF/ID load with valid=1.
REQ-033 With FETCH_PERF_EN defined, squash_count SHALL increment on each cycle in which flush or redirect discards a valid IF/ID entry or the instruction currently being fetched.
REQ-034 With FETCH_PERF_EN defined, both counters SHALL saturate at 32'hFFFF_FFFF.
REQ-035 Without FETCH_PERF_EN, the ports SHALL remain present, SHALL be constant 0, and the counter logic SHALL not be synthesized.

Verification
REQ-036 Reset release -> imem_addr=32'h0000_0000 in cycle 0; id_pc_4=32'h0040_0004 and id_valid=1 in cycle 1; pc=32'h0040_0008 in cycle 2.
REQ-037 stall=1 for 3 cycles at pc=32'h0040_0010 -> pc and id_* frozen for 3 cycles; pc=32'h0040_0014 on the cycle after release.
REQ-038 redirect_valid=1 with redirect_pc=32'h0040_0103 and stall=1 -> next pc=32'h0040_0100, id_valid=0, and squash_count incremented by 1 (FETCH_PERF_EN defined).
REQ-039 flush=1 with stall=1 at pc=32'h0040_0020 -> id_instr=0 and id_valid=0; pc held at 32'h0040_0020.
REQ-040 redirect to 32'hFFFF_FFFC, then free run -> pc=32'h0000_0000 next cycle and imem_addr=32'hFFC0_0000.
REQ-041 With FETCH_PERF_EN undefined, 10 free-running cycles -> fetch_count=0 and squash_count=0 throughout.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of a classic five-stage pipeline. It holds the
// architectural PC, drives the physical instruction-memory address, and
// registers the fetched instruction and its PC+4 into the IF/ID register.
//
// Configuration macro:
//   FETCH_PERF_EN - when defined, fetch_count and squash_count become real
//                   saturating counters. When undefined, both ports read 0
//                   and no counter logic is built.
//
// Parameters:
//   RESET_PC    - architectural PC loaded on reset
//   MEM_OFFSET  - added to the PC to form the physical fetch address
//
// Ports:
//   clk            in   single clock, all state changes on the rising edge
//   reset          in   synchronous, active-high reset
//   stall          in   hold PC and IF/ID
//   flush          in   replace IF/ID with a bubble
//   redirect_valid in   redirect_pc is a valid branch/jump target this cycle
//   redirect_pc    in   redirect target (low two bits ignored)
//   imem_instr     in   combinational instruction-memory read data
//   imem_addr      out  physical fetch address (pc + MEM_OFFSET)
//   pc             out  current architectural PC
//   id_instr       out  registered instruction for decode
//   id_pc_4        out  registered PC+4 of id_instr
//   id_valid       out  id_instr is a real instruction, not a bubble
//   fetch_count    out  instructions delivered to decode
//   squash_count   out  cycles in which an instruction was discarded
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] MEM_OFFSET = 32'hFFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] imem_instr,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_4,
    output logic        id_valid,
    output logic [31:0] fetch_count,
    output logic [31:0] squash_count
);

    logic [31:0] pcPlus4;
    logic        squashIfId;
    logic        loadIfId;

    // Both additions wrap naturally at 32 bits.
    assign pcPlus4   = pc + 32'd4;
    assign imem_addr = pc + MEM_OFFSET;

    // A redirect always kills the instruction fetched this cycle, so it
    // bubbles IF/ID exactly like an explicit flush.
    assign squashIfId = flush | redirect_valid;
    assign loadIfId   = ~squashIfId & ~stall;

    // Redirect targets are word aligned; bits [1:0] are discarded.
    logic unusedRedirectBits;
    assign unusedRedirectBits = ^redirect_pc[1:0];

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            id_instr <= 32'h0000_0000;
            id_pc_4  <= 32'h0000_0000;
            id_valid <= 1'b0;
        end else begin
            // PC: redirect beats stall beats sequential advance.
            if (redirect_valid) begin
                pc <= {redirect_pc[31:2], 2'b00};
            end else if (!stall) begin
                pc <= pcPlus4;
            end

            // IF/ID: bubble beats hold beats load.
            if (squashIfId) begin
                id_instr <= 32'h0000_0000;
                id_pc_4  <= 32'h0000_0000;
                id_valid <= 1'b0;
            end else if (!stall) begin
                id_instr <= imem_instr;
                id_pc_4  <= pcPlus4;
                id_valid <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetchCnt;
    logic [31:0] squashCnt;
    logic        discardEvent;

    // Something is thrown away when a redirect kills the current fetch, when
    // a flush kills the fetch the PC is about to step past, or when a flush
    // drops a valid instruction held in IF/ID. A flush during a stall leaves
    // the current fetch to be repeated, so it only counts a valid IF/ID entry.
    assign discardEvent = redirect_valid | (flush & (id_valid | ~stall));

    always_ff @(posedge clk) begin
        if (reset) begin
            fetchCnt  <= 32'h0000_0000;
            squashCnt <= 32'h0000_0000;
        end else begin
            if (loadIfId && fetchCnt != 32'hFFFF_FFFF) begin
                fetchCnt <= fetchCnt + 32'd1;
            end
            if (discardEvent && squashCnt != 32'hFFFF_FFFF) begin
                squashCnt <= squashCnt + 32'd1;
            end
        end
    end

    assign fetch_count  = fetchCnt;
    assign squash_count = squashCnt;
`else
    logic unusedLoadIfId;
    assign unusedLoadIfId = loadIfId;

    assign fetch_count  = 32'h0000_0000;
    assign squash_count = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. A behavioural model of the fetch stage
// tracks PC, IF/ID contents and the performance counters from the stage's
// rules; a compare process checks every DUT output against it on each falling
// edge. Directed sequences pin the model with literal expectations, then a
// randomized phase exercises stall/flush/redirect/reset combinations.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] MEM_OFFSET = 32'hFFC0_0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_instr;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc_4;
    logic        id_valid;
    logic [31:0] fetch_count;
    logic [31:0] squash_count;

    int tests = 0;
    int fails = 0;

    fetch_stage #(
        .RESET_PC   (RESET_PC),
        .MEM_OFFSET (MEM_OFFSET)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_instr     (imem_instr),
        .imem_addr      (imem_addr),
        .pc             (pc),
        .id_instr       (id_instr),
        .id_pc_4        (id_pc_4),
        .id_valid       (id_valid),
        .fetch_count    (fetch_count),
        .squash_count   (squash_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the physical address.
    function automatic logic [31:0] instrAt(input logic [31:0] addr);
        return {addr[15:0], ~addr[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_instr = instrAt(imem_addr);

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [31:0] mPc;
    logic [31:0] mInstr;
    logic [31:0] mPc4;
    logic        mValid;
    longint      mFetched;
    longint      mSquashed;
    bit          checkEn = 0;

    function automatic logic [31:0] sat32(input longint v);
        return (v > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mPc       = RESET_PC;
            mInstr    = 32'h0;
            mPc4      = 32'h0;
            mValid    = 1'b0;
            mFetched  = 0;
            mSquashed = 0;
        end else begin
            logic [31:0] seqPc;
            logic [31:0] onBus;
            bit          killFetch;
            bit          killHeld;
            seqPc = mPc + 32'd4;
            onBus = instrAt(mPc + MEM_OFFSET);

            // What gets lost this cycle: the fetched word is lost if the
            // PC moves on without it landing in IF/ID; the held word is lost
            // if a bubble overwrites a valid entry.
            killFetch = redirect_valid || (flush && !stall);
            killHeld  = (flush || redirect_valid) && mValid;
            if (killFetch || (flush && mValid)) mSquashed++;

            if (flush || redirect_valid) begin
                mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
            end else if (!stall) begin
                mInstr = onBus; mPc4 = seqPc; mValid = 1'b1;
                mFetched++;
            end

            if (redirect_valid)  mPc = redirect_pc & 32'hFFFF_FFFC;
            else if (!stall)     mPc = seqPc;
            if (killHeld) begin end
        end
        checkEn = 1;
    end

    // Compare process: every DUT output against the model, each falling edge.
    always @(negedge clk) begin
        if (checkEn) begin
            check("cmp_pc",        pc,        mPc);
            check("cmp_imem_addr", imem_addr, mPc + MEM_OFFSET);
            check("cmp_id_instr",  id_instr,  mInstr);
            check("cmp_id_pc_4",   id_pc_4,   mPc4);
            check("cmp_id_valid",  {31'h0, id_valid}, {31'h0, mValid});
`ifdef FETCH_PERF_EN
            check("cmp_fetch_count",  fetch_count,  sat32(mFetched));
            check("cmp_squash_count", squash_count, sat32(mSquashed));
`else
            check("cmp_fetch_count",  fetch_count,  32'h0);
            check("cmp_squash_count", squash_count, 32'h0);
`endif
        end
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic setIn(input bit s, input bit f, input bit rv, input logic [31:0] rp);
        stall = s; flush = f; redirect_valid = rv; redirect_pc = rp;
    endtask

    // ------------------------------------------------------------------
    // Stimulus with literal expectations
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] frozenInstr;
        longint      sqBefore;
        longint      fBefore;

        reset = 1'b1;
        setIn(0, 0, 0, 32'h0);
        cycle();
        cycle();

        // Reset state
        check("rst_pc",       pc,       RESET_PC);
        check("rst_id_instr", id_instr, 32'h0);
        check("rst_id_pc_4",  id_pc_4,  32'h0);
        check("rst_id_valid", {31'h0, id_valid}, 32'h0);
        check("rst_fetch",    fetch_count,  32'h0);
        check("rst_squash",   squash_count, 32'h0);

        // Reset release: cycle 0 fetches RESET_PC at physical address 0
        reset = 1'b0;
        check("c0_imem_addr", imem_addr, 32'h0000_0000);
        check("c0_id_valid",  {31'h0, id_valid}, 32'h0);
        cycle();
        check("c1_id_pc_4",   id_pc_4, 32'h0040_0004);
        check("c1_id_valid",  {31'h0, id_valid}, 32'h1);
        check("c1_id_instr",  id_instr, instrAt(32'h0000_0000));
        cycle();
        check("c2_pc",        pc, 32'h0040_0008);

        // Stall for 3 cycles at pc 0x0040_0010
        setIn(0, 0, 1, 32'h0040_0010);
        cycle();
        setIn(0, 0, 0, 32'h0);
        cycle();
        check("pre_stall_pc", pc, 32'h0040_0014);
        setIn(0, 0, 1, 32'h0040_0010);
        cycle();
        check("stall_start_pc", pc, 32'h0040_0010);
        setIn(0, 0, 0, 32'h0);
        cycle();
        // IF/ID now holds 0x0040_0010's instruction, pc = 0x0040_0014
        setIn(0, 0, 1, 32'h0040_000C);
        cycle();
        setIn(0, 0, 0, 32'h0);
        cycle();
        check("stall_at_pc", pc, 32'h0040_0010);
        check("stall_at_id_pc_4", id_pc_4, 32'h0040_0010);
        frozenInstr = id_instr;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall_pc",       pc,       32'h0040_0010);
            check("stall_id_pc_4",  id_pc_4,  32'h0040_0010);
            check("stall_id_valid", {31'h0, id_valid}, 32'h1);
            check("stall_id_instr", id_instr, instrAt(32'h0040_000C + MEM_OFFSET));
        end
        stall = 1'b0;
        cycle();
        check("stall_release_pc", pc, 32'h0040_0014);
        check("stall_release_id_pc_4", id_pc_4, 32'h0040_0014);

        // Redirect to unaligned target while stalled
        sqBefore = mSquashed;
        setIn(1, 0, 1, 32'h0040_0103);
        cycle();
        check("redir_stall_pc",    pc, 32'h0040_0100);
        check("redir_stall_valid", {31'h0, id_valid}, 32'h0);
`ifdef FETCH_PERF_EN
        check("redir_stall_squash", squash_count, sat32(sqBefore + 1));
`else
        check("redir_stall_squash", squash_count, 32'h0);
`endif

        // Flush + stall at pc 0x0040_0020 with a valid entry in IF/ID
        setIn(0, 0, 1, 32'h0040_001C);
        cycle();
        setIn(0, 0, 0, 32'h0);
        cycle();
        check("pre_flush_pc",    pc, 32'h0040_0020);
        check("pre_flush_valid", {31'h0, id_valid}, 32'h1);
        setIn(1, 1, 0, 32'h0);
        cycle();
        check("flush_stall_instr", id_instr, 32'h0);
        check("flush_stall_pc_4",  id_pc_4,  32'h0);
        check("flush_stall_valid", {31'h0, id_valid}, 32'h0);
        check("flush_stall_pc",    pc, 32'h0040_0020);

        // Redirect to the top of the address space, then wrap
        setIn(0, 0, 1, 32'hFFFF_FFFC);
        cycle();
        setIn(0, 0, 0, 32'h0);
        check("wrap_top_pc", pc, 32'hFFFF_FFFC);
        cycle();
        check("wrap_pc",        pc,        32'h0000_0000);
        check("wrap_imem_addr", imem_addr, 32'hFFC0_0000);
        check("wrap_id_pc_4",   id_pc_4,   32'h0000_0000);
        check("wrap_id_valid",  {31'h0, id_valid}, 32'h1);

        // Ten free-running cycles
        fBefore = mFetched;
        for (int k = 0; k < 10; k++) begin
            cycle();
`ifdef FETCH_PERF_EN
            check("free_fetch", fetch_count, sat32(fBefore + k + 1));
`else
            check("free_fetch",  fetch_count,  32'h0);
            check("free_squash", squash_count, 32'h0);
`endif
        end

        // Reset in the middle of a stall with flush and redirect asserted
        setIn(1, 0, 0, 32'h0);
        cycle();
        reset = 1'b1;
        setIn(1, 1, 1, 32'h1234_5678);
        cycle();
        check("midrst_pc",     pc, RESET_PC);
        check("midrst_valid",  {31'h0, id_valid}, 32'h0);
        check("midrst_instr",  id_instr, 32'h0);
        check("midrst_fetch",  fetch_count, 32'h0);
        check("midrst_squash", squash_count, 32'h0);
        reset = 1'b0;
        setIn(0, 0, 0, 32'h0);

        // Randomized phase, checked by the compare process
        for (int k = 0; k < 400; k++) begin
            stall          = ($urandom_range(0, 99) < 30);
            flush          = ($urandom_range(0, 99) < 15);
            redirect_valid = ($urandom_range(0, 99) < 15);
            redirect_pc    = $urandom;
            reset          = ($urandom_range(0, 99) < 2);
            cycle();
        end

        reset = 1'b0;
        setIn(0, 0, 0, 32'h0);
        cycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
